// File: rtl/mac_accum_if.sv
// Operand-in / result-out stream bundle for mac_accum.
// The master side drives operand beats and result ready; the slave side is the MAC stage.
interface mac_accum_if #(
   parameter int AW    = 2,
   parameter int BW    = 2,
   parameter int ACC_W = 10,
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_a;
   logic [BW-1:0]    in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/mac_accum.sv
// Two-stage multiply-accumulate: registered product, then a saturating per-packet
// accumulator that emits one result beat (sum, term count, overflow) per packet.
module mac_accum #(
   parameter int AW    = 2,
   parameter int BW    = 2,
   parameter int ACC_W = 10,
   parameter int CNT_W = 5
) (
   input logic       clk,
   input logic       rst,
   mac_accum_if.slave bus
);
   localparam int PW = AW + BW;

   // Stage 1: product register
   logic [PW-1:0]    p;
   logic             p_last;
   logic             p_valid;

   // Stage 2: running packet state and result register
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             valid_q;

   logic             p_adv;
   logic             in_fire;
   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic [ACC_W-1:0] sum_sat;
   logic [CNT_W-1:0] cnt_next;

   // NOTE: every signal gets a value on every path through this block, so no
   // latch can be inferred; keep it that way when editing.
   always_comb begin
      // A last term may only move on if the result slot is free or being drained.
      p_adv    = p_valid && !(p_last && valid_q && !bus.out_ready);
      in_fire  = bus.in_valid && (!p_valid || p_adv);
      sum_ext  = {1'b0, acc} + (ACC_W+1)'(p);
      carry    = sum_ext[ACC_W];
      sum_sat  = carry ? '1 : sum_ext[ACC_W-1:0];
      cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p       <= '0;
         p_last  <= 1'b0;
         p_valid <= 1'b0;
      end else if (in_fire) begin
         p       <= PW'(bus.in_a) * PW'(bus.in_b);
         p_last  <= bus.in_last;
         p_valid <= 1'b1;
      end else if (p_adv) begin
         p_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         if (valid_q && bus.out_ready)
            valid_q <= 1'b0;
         if (p_adv) begin
            if (p_last) begin
               // Close the packet; a new result overrides the drain above.
               sum_q   <= sum_sat;
               count_q <= cnt_next;
               ovf_q   <= ovf | carry;
               valid_q <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
               ovf     <= 1'b0;
            end else begin
               acc     <= sum_sat;
               cnt     <= cnt_next;
               ovf     <= ovf | carry;
            end
         end
      end
   end

   assign bus.in_ready  = !p_valid || p_adv;
   assign bus.out_valid = valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: one task per scenario with hand-computed results.
module tb_mac_accum;
   localparam int AW    = 2;
   localparam int BW    = 2;
   localparam int ACC_W = 10;
   localparam int CNT_W = 5;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
      int               cyc;
   } res_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   res_t q[$];

   mac_accum_if #(.AW(AW), .BW(BW), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mac_accum #(.AW(AW), .BW(BW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Record every result beat the consumer takes (handshake completes at next rising edge).
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         res_t r;
         r.sum = bus.out_sum;
         r.cnt = bus.out_count;
         r.ovf = bus.out_ovf;
         r.cyc = cyc;
         q.push_back(r);
      end
   end

   task automatic drive_beat(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++; errors++;
         $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n);
      int guard = 0;
      while (q.size() < n && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (q.size() < n) begin
         errors++;
         $display("FAIL result_timeout: got %0d results required %0d", q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf} !== {1'b1, 1'b0, 10'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b required rdy=1 vld=0 sum=0 cnt=0 ovf=0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      q.delete();
      bus.out_ready = 1'b1;
      drive_beat(2'd3, 2'd3, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL single_early_valid: out_valid=%b required 0", bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf} !== {1'b1, 10'd9, 5'd1, 1'b0}) begin
         errors++;
         $display("FAIL single_result: vld=%b sum=%0d cnt=%0d ovf=%b required vld=1 sum=9 cnt=1 ovf=0",
                  bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || q.size() != 1) begin
         errors++; $display("FAIL single_one_cycle: out_valid=%b beats=%0d required 0 and 1", bus.out_valid, q.size());
      end
   endtask

   task automatic test_table();
      q.delete();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            drive_beat(AW'(i), BW'(j), (i == 3 && j == 3));
      wait_results(1);
      checks++;
      if (q.size() > 0 && {q[0].sum, q[0].cnt, q[0].ovf} !== {10'd36, 5'd16, 1'b0}) begin
         errors++;
         $display("FAIL table_result: sum=%0d cnt=%0d ovf=%b required sum=36 cnt=16 ovf=0", q[0].sum, q[0].cnt, q[0].ovf);
      end
   endtask

   task automatic test_saturation();
      q.delete();
      for (int k = 1; k <= 114; k++)
         drive_beat(2'd3, 2'd3, (k == 114));
      wait_results(1);
      checks++;
      if (q.size() > 0 && {q[0].sum, q[0].cnt, q[0].ovf} !== {10'd1023, 5'd31, 1'b1}) begin
         errors++;
         $display("FAIL sat_result: sum=%0d cnt=%0d ovf=%b required sum=1023 cnt=31 ovf=1", q[0].sum, q[0].cnt, q[0].ovf);
      end
      q.delete();
      drive_beat(2'd1, 2'd1, 1'b1);
      wait_results(1);
      checks++;
      if (q.size() > 0 && {q[0].sum, q[0].cnt, q[0].ovf} !== {10'd1, 5'd1, 1'b0}) begin
         errors++;
         $display("FAIL sat_recover: sum=%0d cnt=%0d ovf=%b required sum=1 cnt=1 ovf=0", q[0].sum, q[0].cnt, q[0].ovf);
      end
   endtask

   task automatic test_backpressure();
      q.delete();
      bus.out_ready = 1'b0;
      drive_beat(2'd2, 2'd3, 1'b1);
      drive_beat(2'd1, 2'd1, 1'b0);
      drive_beat(2'd3, 2'd2, 1'b1);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count} !== {1'b0, 1'b1, 10'd6, 5'd1}) begin
         errors++;
         $display("FAIL bp_stall: rdy=%b vld=%b sum=%0d cnt=%0d required rdy=0 vld=1 sum=6 cnt=1",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count} !== {1'b0, 1'b1, 10'd6, 5'd1} || q.size() != 0) begin
         errors++;
         $display("FAIL bp_hold: rdy=%b vld=%b sum=%0d cnt=%0d beats=%0d required rdy=0 vld=1 sum=6 cnt=1 beats=0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, q.size());
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: in_ready=%b required 1", bus.in_ready);
      end
      wait_results(2);
      checks++;
      if (q.size() >= 2 && ({q[0].sum, q[0].cnt, q[1].sum, q[1].cnt} !== {10'd6, 5'd1, 10'd7, 5'd2}
                            || q[1].cyc != q[0].cyc + 1)) begin
         errors++;
         $display("FAIL bp_results: (%0d,%0d)@%0d then (%0d,%0d)@%0d required (6,1) then (7,2) on consecutive cycles",
                  q[0].sum, q[0].cnt, q[0].cyc, q[1].sum, q[1].cnt, q[1].cyc);
      end
   endtask

   task automatic test_reset_mid_packet();
      q.delete();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++)
         drive_beat(2'd3, 2'd3, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf} !== {1'b1, 1'b0, 10'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL midrst_state: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b required rdy=1 vld=0 sum=0 cnt=0 ovf=0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive_beat(2'd2, 2'd3, 1'b1);
      wait_results(1);
      checks++;
      if (q.size() != 1 || {q[0].sum, q[0].cnt, q[0].ovf} !== {10'd6, 5'd1, 1'b0}) begin
         errors++;
         $display("FAIL midrst_result: beats=%0d sum=%0d cnt=%0d ovf=%b required beats=1 sum=6 cnt=1 ovf=0",
                  q.size(), q[0].sum, q[0].cnt, q[0].ovf);
      end
   endtask

   task automatic test_back_to_back();
      q.delete();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++)
         drive_beat(AW'(k % 4), 2'd1, 1'b1);
      wait_results(8);
      for (int k = 0; k < 8 && k < q.size(); k++) begin
         checks++;
         if (q[k].sum !== ACC_W'(k % 4) || q[k].cnt !== 5'd1 || q[k].ovf !== 1'b0
             || (k > 0 && q[k].cyc != q[k-1].cyc + 1)) begin
            errors++;
            $display("FAIL b2b_result[%0d]: sum=%0d cnt=%0d ovf=%b cyc=%0d required sum=%0d cnt=1 ovf=0 consecutive",
                     k, q[k].sum, q[k].cnt, q[k].ovf, q[k].cyc, k % 4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_table();
      test_saturation();
      test_backpressure();
      test_reset_mid_packet();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
